// File: rtl/wbc_arbiter_wdog_pkg.sv
// Shared types and constants for the WISHBONE control-bus
// round-robin arbiter and its bus watchdog.
package wbc_arbiter_wdog_pkg;

  localparam int N_MST = 4;
  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N_MST-1:0] vec_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_TERM = 2'd2
  } arb_state_e;

  localparam idx_t PCIC  = 2'd0;
  localparam idx_t TURFC = 2'd1;
  localparam idx_t HKMC  = 2'd2;
  localparam idx_t WBVIO = 2'd3;

  function automatic vec_t onehot(idx_t i);
    vec_t v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wbc_arbiter_wdog_if.sv
// Bundle of master requests, muxed slave terminations and
// arbiter/watchdog status for the control-bus arbiter.
interface wbc_arbiter_wdog_if
  import wbc_arbiter_wdog_pkg::*;
#(
  parameter int CNT_W = 16
);

  vec_t             cyc_i;
  vec_t             stb_i;
  logic             ack_i;
  logic             err_i;
  logic             rty_i;
  logic             wdog_en_i;
  logic             cnt_clr_i;
  vec_t             gnt_o;
  logic             tmo_err_o;
  logic [CNT_W-1:0] tmo_cnt_o;
  idx_t             tmo_last_o;
  logic             busy_o;

  modport master (
    output cyc_i, stb_i,
    output ack_i, err_i, rty_i,
    output wdog_en_i, cnt_clr_i,
    input  gnt_o, tmo_err_o,
    input  tmo_cnt_o, tmo_last_o,
    input  busy_o
  );

  modport slave (
    input  cyc_i, stb_i,
    input  ack_i, err_i, rty_i,
    input  wdog_en_i, cnt_clr_i,
    output gnt_o, tmo_err_o,
    output tmo_cnt_o, tmo_last_o,
    output busy_o
  );

endinterface

// File: rtl/wbc_rr_pick.sv
// Combinational round-robin picker: first set request
// searching last+1, last+2, ... modulo the master count.
module wbc_rr_pick
  import wbc_arbiter_wdog_pkg::*;
(
  input  vec_t req,
  input  idx_t last,
  output idx_t pick,
  output logic valid
);

  idx_t cand;

  // Walk from lowest to highest priority so the nearest hit wins.
  always_comb begin
    pick  = last;
    valid = 1'b0;
    cand  = last;
    for (int i = N_MST; i >= 1; i--) begin
      cand = last + idx_t'(i);
      if (req[cand]) begin
        pick  = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wbc_arbiter_wdog.sv
// Four-master round-robin grant controller with a stalled-strobe
// watchdog that injects a one-cycle error and counts events.
module wbc_arbiter_wdog
  import wbc_arbiter_wdog_pkg::*;
#(
  parameter int NMASTERS = 4,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  wbc_arbiter_wdog_if.slave bus
);

  localparam logic [15:0] WLIM = 16'(TIMEOUT - 1);

  arb_state_e          state_q;
  arb_state_e          state_d;
  idx_t                last_q;
  idx_t                last_d;
  logic [NMASTERS-1:0] gnt_q;
  logic [NMASTERS-1:0] gnt_d;
  logic [15:0]         wcnt_q;
  logic [15:0]         wcnt_d;
  logic                terr_q;
  logic [CNT_W-1:0]    tcnt_q;
  idx_t                tlast_q;

  idx_t pick;
  logic pick_v;
  logic own_cyc;
  logic term;
  logic stall;
  logic hit;

  wbc_rr_pick u_pick (
    .req  (bus.cyc_i),
    .last (last_q),
    .pick (pick),
    .valid(pick_v)
  );

  // last_q is also the granted index while BUSY/TERM.
  assign own_cyc = bus.cyc_i[last_q];
  assign term    = bus.ack_i | bus.err_i | bus.rty_i;
  assign stall   = bus.wdog_en_i
                 & bus.stb_i[last_q]
                 & ~term;
  assign hit     = stall & (wcnt_q == WLIM);

  // State, grant, pointer and watchdog counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      last_q  <= WBVIO;
      gnt_q   <= '0;
      wcnt_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wcnt_q  <= wcnt_d;
      terr_q  <= (state_d == ARB_TERM);
    end
  end

  // Next-state: grant on arbitration, release on cyc drop,
  // enter TERM when the stall count reaches the limit.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wcnt_d  = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_v) begin
          state_d = ARB_BUSY;
          last_d  = pick;
          gnt_d   = onehot(pick);
        end
      end
      ARB_BUSY: begin
        if (!own_cyc) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
        end else if (hit) begin
          state_d = ARB_TERM;
        end else if (stall) begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      ARB_TERM: begin
        state_d = ARB_BUSY;
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Event counter and last-offender capture; clear beats TERM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tcnt_q  <= '0;
      tlast_q <= '0;
    end else begin
      if (bus.cnt_clr_i) begin
        tcnt_q <= '0;
      end else if (state_q == ARB_TERM
                   && tcnt_q != '1) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
      if (state_q == ARB_TERM) begin
        tlast_q <= last_q;
      end
    end
  end

  // Drive the status outputs from registered state.
  always_comb begin
    bus.gnt_o      = gnt_q;
    bus.tmo_err_o  = terr_q;
    bus.tmo_cnt_o  = tcnt_q;
    bus.tmo_last_o = tlast_q;
    bus.busy_o     = (state_q != ARB_IDLE);
  end

endmodule

// File: tb/tb_wbc_arbiter_wdog.sv
// Scoreboard bench for wbc_arbiter_wdog: a request/stall model
// predicts grant, timeout and count events checked by a monitor.
module tb_wbc_arbiter_wdog;

  localparam int TMO  = 8;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wbc_arbiter_wdog_if #(.CNT_W(CW)) bus ();

  wbc_arbiter_wdog #(
    .NMASTERS(4),
    .TIMEOUT (TMO),
    .CNT_W   (CW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int stamp;
    int kind;
    int idx;
    int cnt;
  } ev_t;

  ev_t  q[$];
  int   gseq[$];
  int   total = 0;
  int   bad = 0;
  int   edge_n = 0;
  int   g_stamp = 0;
  int   t_stamp = 0;
  bit   rst_flag = 1'b1;
  logic [3:0] prev_gnt = '0;
  logic prev_tmo = 1'b0;

  int m_owner;
  int m_ptr;
  int m_stall;
  int m_tcnt;
  int m_tlast;
  bit m_term;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic flag(string nm, int a, int b);
    total++;
    bad++;
    $display("FAIL %s info=%0d/%0d t=%0t", nm, a, b, $time);
  endtask

  function automatic int gidx(logic [3:0] g);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic push(int k, int i, int c);
    ev_t e;
    e.stamp = edge_n + 1;
    e.kind  = k;
    e.idx   = i;
    e.cnt   = c;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 3;
    m_stall = 0;
    m_tcnt  = 0;
    m_tlast = 0;
    m_term  = 1'b0;
  endtask

  // Predicts the effect of the coming clock edge.
  task automatic model_step(logic [3:0] c, logic [3:0] s,
                            logic a, logic e, logic r,
                            logic en, logic clr);
    bit was_term;
    bit found;
    int cand;
    was_term = m_term;
    if (clr) m_tcnt = 0;
    else if (was_term && m_tcnt < CMAX) m_tcnt++;
    if (was_term) begin
      m_tlast = m_owner;
      m_term  = 1'b0;
      push(2, m_tlast, m_tcnt);
    end
    if (m_owner < 0) begin
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
        cand = (m_ptr + i) % 4;
        if (!found && c[cand]) begin
          found   = 1'b1;
          m_owner = cand;
          m_ptr   = cand;
          m_stall = 0;
          push(0, cand, 0);
        end
      end
    end else if (!was_term) begin
      if (!c[m_owner]) begin
        m_owner = -1;
        m_stall = 0;
      end else if (en && s[m_owner] && !a && !e && !r) begin
        if (m_stall == TMO - 1) begin
          m_term  = 1'b1;
          m_stall = 0;
          push(1, m_owner, 0);
        end else begin
          m_stall++;
        end
      end else begin
        m_stall = 0;
      end
    end
  endtask

  task automatic step(logic [3:0] c, logic [3:0] s,
                      logic a, logic e, logic r,
                      logic en, logic clr, logic clr_term);
    logic cl;
    @(negedge clk);
    cl = clr | (clr_term & bus.tmo_err_o);
    bus.cyc_i     = c;
    bus.stb_i     = s;
    bus.ack_i     = a;
    bus.err_i     = e;
    bus.rty_i     = r;
    bus.wdog_en_i = en;
    bus.cnt_clr_i = cl;
    model_step(c, s, a, e, r, en, cl);
  endtask

  task automatic drive_zero();
    bus.cyc_i     = '0;
    bus.stb_i     = '0;
    bus.ack_i     = 1'b0;
    bus.err_i     = 1'b0;
    bus.rty_i     = 1'b0;
    bus.wdog_en_i = 1'b0;
    bus.cnt_clr_i = 1'b0;
  endtask

  task automatic stall1(logic [3:0] m);
    step(m, m, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    rst_flag = 1'b1;
    q.delete();
    model_reset();
    #1;
    chk("arst_gnt", bus.gnt_o, 0);
    chk("arst_busy", bus.busy_o, 0);
    chk("arst_err", bus.tmo_err_o, 0);
    drive_zero();
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    rst_flag = 1'b0;
  endtask

  task automatic until_gnt(logic [3:0] c, logic [3:0] s,
                           logic [3:0] want);
    int k;
    k = 0;
    do begin
      step(c, s, 0, 0, 0, 1, 0, 0);
      k++;
    end while (bus.gnt_o != want && k < 20);
    if (bus.gnt_o != want) flag("grant_wait", bus.gnt_o, want);
  endtask

  // Monitor: consume one expected event per DUT presentation.
  always @(negedge clk) begin
    ev_t e;
    if (!rst_flag) begin
      while (q.size() > 0 && q[0].stamp < edge_n) begin
        flag("missing_event", q[0].kind, q[0].stamp);
        e = q.pop_front();
      end
      if (prev_gnt == 0 && bus.gnt_o != 0) begin
        gseq.push_back(gidx(bus.gnt_o));
        g_stamp = edge_n;
        if (q.size() == 0) begin
          flag("unexpected_grant", bus.gnt_o, edge_n);
        end else begin
          e = q.pop_front();
          chk("grant_kind", 0, e.kind);
          chk("grant_time", edge_n, e.stamp);
          chk("grant_vec", bus.gnt_o, 1 << e.idx);
        end
      end
      if (bus.tmo_err_o) begin
        t_stamp = edge_n;
        if (q.size() == 0) begin
          flag("unexpected_tmo", bus.gnt_o, edge_n);
        end else begin
          e = q.pop_front();
          chk("tmo_kind", 1, e.kind);
          chk("tmo_time", edge_n, e.stamp);
          chk("tmo_gnt_held", bus.gnt_o, 1 << e.idx);
        end
      end
      if (prev_tmo) begin
        if (q.size() == 0) begin
          flag("unexpected_cnt", bus.tmo_cnt_o, edge_n);
        end else begin
          e = q.pop_front();
          chk("cnt_kind", 2, e.kind);
          chk("cnt_time", edge_n, e.stamp);
          chk("tmo_cnt", bus.tmo_cnt_o, e.cnt);
          chk("tmo_last", bus.tmo_last_o, e.idx);
        end
      end
    end
    prev_gnt = bus.gnt_o;
    prev_tmo = bus.tmo_err_o;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout t=%0t", $time);
    $fatal(1, "bench time limit");
  end

  initial begin
    int ord[5];
    int n;
    int k;
    int held;
    int drop;
    logic [3:0] m;
    logic [3:0] c;
    logic [3:0] s;

    ord = '{0, 1, 2, 3, 0};
    drive_zero();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    rst_flag = 1'b0;
    #1;
    chk("rst_gnt", bus.gnt_o, 0);
    chk("rst_err", bus.tmo_err_o, 0);
    chk("rst_cnt", bus.tmo_cnt_o, 0);
    chk("rst_last", bus.tmo_last_o, 0);
    chk("rst_busy", bus.busy_o, 0);

    // Two requesters, master 0 first, then master 2.
    step(4'b0101, 0, 0, 0, 0, 1, 0, 0);
    step(4'b0101, 0, 0, 0, 0, 1, 0, 0);
    chk("p1_gnt0", bus.gnt_o, 4'b0001);
    chk("p1_busy", bus.busy_o, 1);
    repeat (3) step(4'b0101, 0, 0, 0, 0, 1, 0, 0);
    step(4'b0100, 0, 0, 0, 0, 1, 0, 0);
    step(4'b0100, 0, 0, 0, 0, 1, 0, 0);
    chk("p1_idle_gap", bus.gnt_o, 0);
    step(4'b0100, 0, 0, 0, 0, 1, 0, 0);
    chk("p1_gnt2", bus.gnt_o, 4'b0100);
    repeat (2) step(0, 0, 0, 0, 0, 1, 0, 0);

    // All four requesting, each holds for three cycles.
    do_reset();
    gseq.delete();
    held = 0;
    drop = -1;
    repeat (40) begin
      if (bus.gnt_o != 0) begin
        held++;
        if (held == 3) drop = gidx(bus.gnt_o);
      end else begin
        held = 0;
        drop = -1;
      end
      m = 4'hF;
      if (drop >= 0) m[drop] = 1'b0;
      step(m, 0, 0, 0, 0, 1, 0, 0);
    end
    if (gseq.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", gseq[i], ord[i]);
    end else begin
      flag("rr_short", gseq.size(), 5);
    end
    repeat (2) step(0, 0, 0, 0, 0, 1, 0, 0);

    // Master 1 stalls until the watchdog fires.
    do_reset();
    until_gnt(4'b0010, 4'b0010, 4'b0010);
    repeat (12) stall1(4'b0010);
    chk("tmo_latency", t_stamp - g_stamp, 8);
    chk("p3_cnt", bus.tmo_cnt_o, 1);
    chk("p3_last", bus.tmo_last_o, 1);

    // Ack at threshold, then a stb gap restarts the count.
    repeat (2) step(0, 0, 0, 0, 0, 1, 0, 0);
    until_gnt(4'b0010, 4'b0010, 4'b0010);
    repeat (6) stall1(4'b0010);
    step(4'b0010, 4'b0010, 1, 0, 0, 1, 0, 0);
    repeat (5) stall1(4'b0010);
    step(4'b0010, 4'b0000, 0, 0, 0, 1, 0, 0);
    repeat (7) stall1(4'b0010);
    step(4'b0010, 4'b0010, 1, 0, 0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("p4_cnt_kept", bus.tmo_cnt_o, 1);

    // Saturation, then a clear coinciding with TERM.
    do_reset();
    n = 0;
    k = 0;
    while (n < 4 && k < 100) begin
      stall1(4'b1000);
      if (bus.tmo_err_o) n++;
      k++;
    end
    if (n < 4) flag("sat_wait", n, 4);
    repeat (2) stall1(4'b1000);
    chk("p5_sat", bus.tmo_cnt_o, 3);
    n = 0;
    k = 0;
    while (n < 1 && k < 30) begin
      step(4'b1000, 4'b1000, 0, 0, 0, 1, 0, 1);
      if (bus.tmo_err_o) n++;
      k++;
    end
    if (n < 1) flag("clr_wait", n, 1);
    stall1(4'b1000);
    chk("p5_clr_wins", bus.tmo_cnt_o, 0);
    chk("p5_last", bus.tmo_last_o, 3);

    // Async reset mid-stall, then master 0 wins.
    do_reset();
    until_gnt(4'b0100, 4'b0100, 4'b0100);
    repeat (5) stall1(4'b0100);
    do_reset();
    until_gnt(4'b1111, 4'b0000, 4'b0001);
    chk("p6_gnt0", bus.gnt_o, 4'b0001);
    repeat (2) step(0, 0, 0, 0, 0, 1, 0, 0);

    // Random traffic against the model.
    do_reset();
    c = '0;
    repeat (3000) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom % 16 == 0) c[i] = ~c[i];
        s[i] = c[i] & ($urandom % 8 != 0);
      end
      step(c, s,
           ($urandom % 16 == 0),
           ($urandom % 64 == 0),
           ($urandom % 64 == 0),
           ($urandom % 16 != 0),
           ($urandom % 64 == 0),
           0);
    end
    repeat (5) step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("queue_empty", q.size(), 0);
    chk("final_cnt", bus.tmo_cnt_o, m_tcnt);
    chk("final_last", bus.tmo_last_o, m_tlast);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
